id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Single-entry decode-to-execute pipeline register with valid/ready handshake.
- Sits directly upstream of the ALU and drives its alu_ctrl, in_1 and in_2 inputs.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Selects ALU operand sources: rs1 or PC for operand 1, rs2 or immediate for operand 2.

Parameters:
- DATA_WIDTH, 32, width of data, PC and immediate paths.
- REG_IDX_W, 5, register index width.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill the held entry and any same-cycle capture.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  DATA_WIDTH  instruction PC.
- in_rs1_val, in_rs2_val  in  DATA_WIDTH  register-file read data.
- in_imm  in  DATA_WIDTH  sign-extended immediate.
- in_rs1_idx, in_rs2_idx, in_rd_idx  in  REG_IDX_W  register indices.
- in_alu_ctrl  in  4  ALU op code (ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111).
- in_src1_sel  in  1  0=rs1, 1=PC.
- in_src2_sel  in  1  0=rs2, 1=immediate.
- in_reg_we  in  1  instruction writes rd.
- fwd_mem_we, fwd_mem_rd, fwd_mem_data  in  1/REG_IDX_W/DATA_WIDTH  EX/MEM result bus.
- fwd_wb_we, fwd_wb_rd, fwd_wb_data  in  1/REG_IDX_W/DATA_WIDTH  MEM/WB result bus.
- out_valid  out  1  entry valid toward the ALU.
- out_ready  in  1  downstream accepts.
- alu_ctrl  out  4  registered ALU op.
- alu_in_1, alu_in_2  out  DATA_WIDTH  ALU operands.
- out_rs2_val  out  DATA_WIDTH  forwarded rs2 (store data).
- out_pc  out  DATA_WIDTH  registered PC.
- out_rd_idx  out  REG_IDX_W  registered rd.
- out_reg_we  out  1  registered write enable, gated by out_valid.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; all held fields 0.
  - alu_ctrl=0000 (ADD), so alu_in_1=alu_in_2=0.
  - in_ready=1 after reset.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Capture when in_valid & in_ready & !flush; latency 1 cycle; full throughput, one instruction per cycle.
- out_valid next-state:
  - flush → 0. Flush overrides a simultaneous capture; the offered instruction is dropped.
  - Else capture → 1.
  - Else out_ready → 0.
  - Else hold.
- Hold state (out_valid & !out_ready): alu_ctrl, pc, imm, indices, sel bits and reg_we are frozen.
- Forwarded value fwd_rsN (N=1,2), priority order:
  1. Index 0 → held value; x0 is never forwarded.
  2. fwd_mem_we & fwd_mem_rd==idx → fwd_mem_data.
  3. fwd_wb_we & fwd_wb_rd==idx → fwd_wb_data.
  4. Otherwise → held rsN value.
- Refresh on hold: every cycle in hold state, held rsN value <= fwd_rsN. A producer that retires while the entry is stalled is therefore not lost.
- Outputs (combinational from held state and forward buses):
  - alu_in_1 = src1_sel ? pc : fwd_rs1.
  - alu_in_2 = src2_sel ? imm : fwd_rs2.
  - out_rs2_val = fwd_rs2.
  - Operand outputs may change during hold only because of forwarding.
- out_reg_we = held reg_we & out_valid.
- Reset mid-operation: the entry is discarded immediately.
- Load-use stalls are not detected here; upstream hazard logic withholds in_valid.

Optional Feature:
- Macro ID_EX_FWD_EN.
- Defined: forwarding and hold-refresh as above.
- Undefined:
  - fwd_* ports remain in the interface but are ignored.
  - fwd_rsN = held rsN value.
  - No refresh during hold.
  - Handshake behaviour is unchanged.

Test Plan:
- Reset, then release: out_valid=0, alu_ctrl=0000, alu_in_1=alu_in_2=0, in_ready=1.
- Capture ADD rs1=5 (val 0x10), src2_sel=1, imm=0x20, out_ready=1 → next cycle out_valid=1, alu_ctrl=0000, alu_in_1=0x10, alu_in_2=0x20.
- Priority: held rs1=3 with fwd_mem(rd=3,data=0xAA) and fwd_wb(rd=3,data=0xBB) both active → alu_in_1=0xAA. With mem_we=0 → 0xBB. With rs1=0 and both buses rd=0 → held value.
- Stall refresh: out_ready=0, fwd_wb(rd=7,data=0x55) pulses for one cycle on a held rs2=7 entry. Later cycles with buses idle → alu_in_2=0x55. Then out_ready=1 → entry retires.
- Flush with simultaneous in_valid=1, in_ready=1 → next cycle out_valid=0 and the new instruction is not captured.
- Back-to-back: in_valid=out_ready=1 for 4 cycles with SUB, SLT, SRA, AND → four consecutive out_valid cycles carrying codes 1000, 0010, 1101, 0111 in order.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: single-entry decode-to-execute pipeline register with valid/ready handshake,
// operand source selection and RAW forwarding from the EX/MEM and MEM/WB result buses.
// Optional feature macro: ID_EX_FWD_EN (forwarding and refresh-on-hold). When it is undefined,
// the fwd_* ports are ignored and operands come straight from the captured register values.
module id_ex_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_IDX_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_rs1_val,
    input  logic [DATA_WIDTH-1:0] in_rs2_val,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [REG_IDX_W-1:0]  in_rs1_idx,
    input  logic [REG_IDX_W-1:0]  in_rs2_idx,
    input  logic [REG_IDX_W-1:0]  in_rd_idx,
    input  logic [3:0]            in_alu_ctrl,
    input  logic                  in_src1_sel,
    input  logic                  in_src2_sel,
    input  logic                  in_reg_we,
    input  logic                  fwd_mem_we,
    input  logic [REG_IDX_W-1:0]  fwd_mem_rd,
    input  logic [DATA_WIDTH-1:0] fwd_mem_data,
    input  logic                  fwd_wb_we,
    input  logic [REG_IDX_W-1:0]  fwd_wb_rd,
    input  logic [DATA_WIDTH-1:0] fwd_wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            alu_ctrl,
    output logic [DATA_WIDTH-1:0] alu_in_1,
    output logic [DATA_WIDTH-1:0] alu_in_2,
    output logic [DATA_WIDTH-1:0] out_rs2_val,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [REG_IDX_W-1:0]  out_rd_idx,
    output logic                  out_reg_we
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] rs1_val_q;
    logic [DATA_WIDTH-1:0] rs2_val_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [REG_IDX_W-1:0]  rs1_idx_q;
    logic [REG_IDX_W-1:0]  rs2_idx_q;
    logic [REG_IDX_W-1:0]  rd_idx_q;
    logic [3:0]            alu_ctrl_q;
    logic                  src1_sel_q;
    logic                  src2_sel_q;
    logic                  reg_we_q;

    logic                  capture;
    logic                  hold;
    logic [DATA_WIDTH-1:0] fwd_rs1;
    logic [DATA_WIDTH-1:0] fwd_rs2;

    assign in_ready = ~valid_q | out_ready;
    assign capture  = in_valid & in_ready & ~flush;
    assign hold     = valid_q & ~out_ready;

`ifdef ID_EX_FWD_EN
    // EX/MEM beats MEM/WB since it is the younger producer; x0 is never forwarded.
    function automatic logic [DATA_WIDTH-1:0] fwd_pick(
        input logic [REG_IDX_W-1:0]  idx,
        input logic [DATA_WIDTH-1:0] held,
        input logic                  mem_we,
        input logic [REG_IDX_W-1:0]  mem_rd,
        input logic [DATA_WIDTH-1:0] mem_data,
        input logic                  wb_we,
        input logic [REG_IDX_W-1:0]  wb_rd,
        input logic [DATA_WIDTH-1:0] wb_data
    );
        logic [DATA_WIDTH-1:0] val;
        val = held;
        if (idx != '0) begin
            if (mem_we && mem_rd == idx) begin
                val = mem_data;
            end else if (wb_we && wb_rd == idx) begin
                val = wb_data;
            end
        end
        return val;
    endfunction

    // Resolve RAW hazards against both result buses.
    always_comb begin
        fwd_rs1 = fwd_pick(rs1_idx_q, rs1_val_q, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_we, fwd_wb_rd, fwd_wb_data);
        fwd_rs2 = fwd_pick(rs2_idx_q, rs2_val_q, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_we, fwd_wb_rd, fwd_wb_data);
    end
`else
    // Forwarding disabled: operands are the captured register-file values.
    always_comb begin
        fwd_rs1 = rs1_val_q;
        fwd_rs2 = rs2_val_q;
    end

    logic unused_fwd;
    assign unused_fwd = ^{fwd_mem_we, fwd_mem_rd, fwd_mem_data, fwd_wb_we, fwd_wb_rd,
                          fwd_wb_data, rs1_idx_q, rs2_idx_q, hold};
`endif

    // Entry valid flag: flush wins over capture, retire clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Payload: load on capture; while stalled, fold in forwarded values so a producer
    // that retires during the stall is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            rs1_val_q  <= '0;
            rs2_val_q  <= '0;
            imm_q      <= '0;
            rs1_idx_q  <= '0;
            rs2_idx_q  <= '0;
            rd_idx_q   <= '0;
            alu_ctrl_q <= 4'b0000;
            src1_sel_q <= 1'b0;
            src2_sel_q <= 1'b0;
            reg_we_q   <= 1'b0;
        end else if (capture) begin
            pc_q       <= in_pc;
            rs1_val_q  <= in_rs1_val;
            rs2_val_q  <= in_rs2_val;
            imm_q      <= in_imm;
            rs1_idx_q  <= in_rs1_idx;
            rs2_idx_q  <= in_rs2_idx;
            rd_idx_q   <= in_rd_idx;
            alu_ctrl_q <= in_alu_ctrl;
            src1_sel_q <= in_src1_sel;
            src2_sel_q <= in_src2_sel;
            reg_we_q   <= in_reg_we;
`ifdef ID_EX_FWD_EN
        end else if (hold) begin
            rs1_val_q  <= fwd_rs1;
            rs2_val_q  <= fwd_rs2;
`endif
        end
    end

    // Outputs toward the ALU and later stages.
    always_comb begin
        out_valid   = valid_q;
        alu_ctrl    = alu_ctrl_q;
        alu_in_1    = src1_sel_q ? pc_q : fwd_rs1;
        alu_in_2    = src2_sel_q ? imm_q : fwd_rs2;
        out_rs2_val = fwd_rs2;
        out_pc      = pc_q;
        out_rd_idx  = rd_idx_q;
        out_reg_we  = reg_we_q & valid_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage. Expectations follow ID_EX_FWD_EN.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;
`ifdef ID_EX_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [RW-1:0] in_rs1_idx, in_rs2_idx, in_rd_idx;
    logic [3:0]    in_alu_ctrl;
    logic          in_src1_sel, in_src2_sel, in_reg_we;
    logic          fwd_mem_we, fwd_wb_we;
    logic [RW-1:0] fwd_mem_rd, fwd_wb_rd;
    logic [DW-1:0] fwd_mem_data, fwd_wb_data;
    logic          out_valid, out_ready;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] alu_in_1, alu_in_2, out_rs2_val, out_pc;
    logic [RW-1:0] out_rd_idx;
    logic          out_reg_we;

    typedef struct packed {
        logic [3:0]    ctrl;
        logic [DW-1:0] pc, rs1v, rs2v, imm;
        logic [RW-1:0] rs1i, rs2i, rd;
        logic          s1, s2, we;
    } instr_t;

    typedef struct packed {
        logic [3:0]    ctrl;
        logic [DW-1:0] in1, in2, rs2, pc;
        logic [RW-1:0] rd;
        logic          we;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;
    int   n_pops = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    id_ex_stage #(.DATA_WIDTH(DW), .REG_IDX_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx),
        .in_alu_ctrl(in_alu_ctrl), .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
        .in_reg_we(in_reg_we),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .out_rs2_val(out_rs2_val), .out_pc(out_pc), .out_rd_idx(out_rd_idx),
        .out_reg_we(out_reg_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(input logic [3:0] ctrl, input logic [DW-1:0] pc,
                                  input logic [RW-1:0] rs1i, input logic [DW-1:0] rs1v,
                                  input logic [RW-1:0] rs2i, input logic [DW-1:0] rs2v,
                                  input logic [DW-1:0] imm, input logic [RW-1:0] rd,
                                  input logic s1, input logic s2, input logic we);
        instr_t i;
        i.ctrl = ctrl; i.pc = pc; i.rs1i = rs1i; i.rs1v = rs1v; i.rs2i = rs2i;
        i.rs2v = rs2v; i.imm = imm; i.rd = rd; i.s1 = s1; i.s2 = s2; i.we = we;
        return i;
    endfunction

    // Expected ALU-side view of an instruction with the result buses idle.
    function automatic exp_t model(input instr_t i);
        exp_t e;
        e.ctrl = i.ctrl;
        e.in1  = i.s1 ? i.pc : i.rs1v;
        e.in2  = i.s2 ? i.imm : i.rs2v;
        e.rs2  = i.rs2v;
        e.pc   = i.pc;
        e.rd   = i.rd;
        e.we   = i.we;
        return e;
    endfunction

    task automatic send(input instr_t i, input bit push);
        in_valid    = 1'b1;
        in_alu_ctrl = i.ctrl;
        in_pc       = i.pc;
        in_rs1_idx  = i.rs1i;
        in_rs1_val  = i.rs1v;
        in_rs2_idx  = i.rs2i;
        in_rs2_val  = i.rs2v;
        in_imm      = i.imm;
        in_rd_idx   = i.rd;
        in_src1_sel = i.s1;
        in_src2_sel = i.s2;
        in_reg_we   = i.we;
        if (push) sb.push_back(model(i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        fwd_mem_we = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
        fwd_wb_we  = 1'b0; fwd_wb_rd  = '0; fwd_wb_data  = '0;
    endtask

    // Scoreboard monitor: every retiring entry is compared with the oldest expectation.
    always @(negedge clk) begin
        if (mon_en && rst_n && out_valid && out_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                n_pops++;
                check("sb_ctrl", 64'(alu_ctrl), 64'(mon_e.ctrl));
                check("sb_in1", 64'(alu_in_1), 64'(mon_e.in1));
                check("sb_in2", 64'(alu_in_2), 64'(mon_e.in2));
                check("sb_rs2", 64'(out_rs2_val), 64'(mon_e.rs2));
                check("sb_pc", 64'(out_pc), 64'(mon_e.pc));
                check("sb_rd", 64'(out_rd_idx), 64'(mon_e.rd));
                check("sb_we", 64'(out_reg_we), 64'(mon_e.we));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t bb[4];
        int pops0;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        send(mk(4'h0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0), 1'b0);
        in_valid = 1'b0;
        bus_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ctrl", 64'(alu_ctrl), 64'd0);
        check("rst_in1", 64'(alu_in_1), 64'd0);
        check("rst_in2", 64'(alu_in_2), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_we", 64'(out_reg_we), 64'd0);

        // Simple ADD with immediate operand.
        tick();
        mon_en = 1'b1; out_ready = 1'b1;
        send(mk(4'b0000, 32'h100, 5'd5, 32'h10, 5'd6, 32'h99, 32'h20, 5'd1, 1'b0, 1'b1, 1'b1), 1'b1);
        tick();
        in_valid = 1'b0;
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_in1", 64'(alu_in_1), 64'h10);
        check("add_in2", 64'(alu_in_2), 64'h20);
        tick();
        check("add_retired", 64'(out_valid), 64'd0);
        mon_en = 1'b0;

        // Forwarding priority on a stalled entry.
        out_ready = 1'b0;
        send(mk(4'b0000, 32'h104, 5'd3, 32'h11, 5'd0, 32'h0, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1), 1'b0);
        tick();
        in_valid = 1'b0;
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'hAA;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd3; fwd_wb_data  = 32'hBB;
        #1 check("pri_mem", 64'(alu_in_1), FwdEn ? 64'hAA : 64'h11);
        fwd_mem_we = 1'b0;
        #1 check("pri_wb", 64'(alu_in_1), FwdEn ? 64'hBB : 64'h11);
        bus_idle();
        #1 check("hold_ready", 64'(in_ready), 64'd0);

        // x0 is never forwarded.
        out_ready = 1'b1;
        send(mk(4'b0000, 32'h108, 5'd0, 32'h33, 5'd0, 32'h0, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1), 1'b0);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'hAA;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd0; fwd_wb_data  = 32'hBB;
        #1 check("x0_held", 64'(alu_in_1), 64'h33);
        bus_idle();

        // Refresh while stalled: a one-cycle WB pulse must stick.
        out_ready = 1'b1;
        send(mk(4'b0000, 32'h200, 5'd0, 32'h0, 5'd7, 32'h01, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1), 1'b0);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        fwd_wb_we = 1'b1; fwd_wb_rd = 5'd7; fwd_wb_data = 32'h55;
        tick();
        bus_idle();
        #1;
        check("refresh_in2", 64'(alu_in_2), FwdEn ? 64'h55 : 64'h01);
        check("refresh_rs2", 64'(out_rs2_val), FwdEn ? 64'h55 : 64'h01);
        tick();
        check("refresh_in2_b", 64'(alu_in_2), FwdEn ? 64'h55 : 64'h01);
        check("refresh_valid", 64'(out_valid), 64'd1);
        check("refresh_in1_pc", 64'(alu_in_1), 64'h200);
        out_ready = 1'b1;
        tick();
        check("refresh_retired", 64'(out_valid), 64'd0);

        // Flush drops a simultaneously offered instruction.
        send(mk(4'b0100, 32'h300, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1), 1'b0);
        flush = 1'b1;
        #1 check("flush_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_we", 64'(out_reg_we), 64'd0);

        // Flush kills a stalled entry.
        out_ready = 1'b0;
        send(mk(4'b0110, 32'h304, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1), 1'b0);
        tick();
        in_valid = 1'b0;
        check("held_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_held", 64'(out_valid), 64'd0);

        // Back-to-back SUB, SLT, SRA, AND at full throughput.
        bb[0] = mk(4'b1000, 32'h400, 5'd1, 32'h100, 5'd2, 32'h30, 32'h0, 5'd8, 1'b0, 1'b0, 1'b1);
        bb[1] = mk(4'b0010, 32'h404, 5'd3, 32'h5, 5'd4, 32'h6, 32'h7, 5'd9, 1'b0, 1'b1, 1'b1);
        bb[2] = mk(4'b1101, 32'h408, 5'd5, 32'h8, 5'd6, 32'h2, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1);
        bb[3] = mk(4'b0111, 32'h40c, 5'd7, 32'hF0F0, 5'd8, 32'hFF, 32'hC, 5'd11, 1'b0, 1'b1, 1'b0);
        pops0 = n_pops;
        mon_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(bb[i], 1'b1);
            tick();
            check("b2b_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("b2b_drained", 64'(sb.size()), 64'd0);
        check("b2b_pops", 64'(n_pops - pops0), 64'd4);
        mon_en = 1'b0;

        // Asynchronous reset mid-operation discards the entry.
        out_ready = 1'b0;
        send(mk(4'b0001, 32'h500, 5'd1, 32'h3, 5'd2, 32'h4, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1), 1'b0);
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in1", 64'(alu_in_1), 64'd0);
        check("mid_rst_we", 64'(out_reg_we), 64'd0);
        #1 rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
